// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rob_pkg
// Description : Shared ROB constants and types (default depth, sequence
//               number type) used by the ROB control blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package rob_pkg;

    // Default number of ROB entries; must be a power of two.
    localparam int c_default_depth = 32;

    // Sequence-number width for the default depth.
    localparam int c_default_ptrwidth = $clog2(c_default_depth);

    // Sequence number as carried through the pipeline.
    typedef logic [c_default_ptrwidth-1:0] sn_t;

endpackage : rob_pkg
`default_nettype wire

// File: rtl/rob_WrapPtr.sv
`default_nettype none
// ============================================================================
// Module      : rob_WrapPtr
// Description : Modulo-DEPTH pointer with synchronous clear and increment.
//               With ROB_SN_ALLOC_FLUSH_EN defined a load port is added so
//               the pointer can be snapped to another pointer's value.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_WrapPtr
    import rob_pkg::*;
#(
    parameter int DEPTH = c_default_depth,
    parameter int WIDTH = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_clr,
`ifdef ROB_SN_ALLOC_FLUSH_EN
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
`endif
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_ptr
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(DEPTH - 1);

    logic [WIDTH-1:0] r_ptr;

    // Pointer register: clear beats load, load beats increment.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_ptr <= '0;
`ifdef ROB_SN_ALLOC_FLUSH_EN
        end else if (i_load) begin
            r_ptr <= i_load_val;
`endif
        end else if (i_inc) begin
            r_ptr <= (r_ptr == c_last) ? '0 : r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule : rob_WrapPtr
`default_nettype wire

// File: rtl/rob_sn_alloc.sv
`default_nettype none
// ============================================================================
// Module      : rob_sn_alloc
// Description : ROB sequence-number allocator. Hands out one sequence number
//               per cycle to dispatch and recycles it when the ROB front is
//               dequeued. Tracks in-flight count, full/empty and a sticky
//               error flag for frees that arrive while nothing is in flight.
//               Optional build macro ROB_SN_ALLOC_FLUSH_EN adds a flush input
//               that abandons all in-flight numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module rob_sn_alloc
    import rob_pkg::*;
#(
    parameter int p_depth    = c_default_depth,
    parameter int p_ptrwidth = $clog2(p_depth)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef ROB_SN_ALLOC_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  alloc_en,
    output logic                  alloc_cpl,
    output logic [p_ptrwidth-1:0] alloc_sn,
    input  logic                  free_en,
    output logic [p_ptrwidth:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  free_err
);

    localparam logic [p_ptrwidth:0] c_depth_cnt = (p_ptrwidth + 1)'(p_depth);

    logic [p_ptrwidth-1:0] w_alloc_ptr;
    logic [p_ptrwidth-1:0] w_free_ptr;
    logic [p_ptrwidth-1:0] w_ptr_diff;
    logic [p_ptrwidth:0]   r_count;
    logic                  r_free_err;
    logic                  w_flush;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_grant;
    logic                  w_free;
    logic                  w_free_bad;

`ifdef ROB_SN_ALLOC_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_full  = (r_count == c_depth_cnt);
    assign w_empty = (r_count == '0);

    // Grant only when a slot is free; a same-cycle free does not make room.
    assign w_grant    = alloc_en && !w_full && !rst && !w_flush;
    assign w_free     = free_en && !w_empty && !rst && !w_flush;
    assign w_free_bad = free_en &&  w_empty && !rst && !w_flush;

    // Outputs read as the cleared state during a reset cycle, even if the
    // registers still hold pre-reset values.
    assign alloc_cpl = w_grant;
    assign alloc_sn  = rst ? '0 : w_alloc_ptr;
    assign count     = rst ? '0 : r_count;
    assign full      = !rst && w_full;
    assign empty     = rst || w_empty;
    assign free_err  = !rst && r_free_err;

    rob_WrapPtr #(
        .DEPTH      (p_depth),
        .WIDTH      (p_ptrwidth)
    ) u_alloc_ptr (
        .clk        (clk),
        .i_clr      (rst),
`ifdef ROB_SN_ALLOC_FLUSH_EN
        .i_load     (w_flush),
        .i_load_val (w_free_ptr),
`endif
        .i_inc      (w_grant),
        .o_ptr      (w_alloc_ptr)
    );

    rob_WrapPtr #(
        .DEPTH      (p_depth),
        .WIDTH      (p_ptrwidth)
    ) u_free_ptr (
        .clk        (clk),
        .i_clr      (rst),
`ifdef ROB_SN_ALLOC_FLUSH_EN
        .i_load     (1'b0),
        .i_load_val (w_free_ptr),
`endif
        .i_inc      (w_free),
        .o_ptr      (w_free_ptr)
    );

    // In-flight count: a grant and a free in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_count <= '0;
        end else begin
            case ({w_grant, w_free})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error for a dequeue with nothing in flight; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_free_err <= 1'b0;
        end else if (w_free_bad) begin
            r_free_err <= 1'b1;
        end
    end

    // Distance between the pointers must always equal the in-flight count
    // (modulo depth); otherwise two live entries could share a number.
    assign w_ptr_diff = w_alloc_ptr - w_free_ptr;

    a_sn_unique : assert property (@(posedge clk) disable iff (rst)
        w_ptr_diff == r_count[p_ptrwidth-1:0]);

endmodule : rob_sn_alloc
`default_nettype wire

// File: tb/tb_rob_sn_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_sn_alloc
// Description : Self-checking bench for rob_sn_alloc at depth 4. A queue of
//               in-flight sequence numbers serves as the reference; directed
//               scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_sn_alloc;

    localparam int DEPTH = 4;
    localparam int W     = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fl  = 1'b0;
    logic         alloc_en = 1'b0;
    logic         free_en  = 1'b0;
    logic         alloc_cpl;
    logic [W-1:0] alloc_sn;
    logic [W:0]   count;
    logic         full;
    logic         empty;
    logic         free_err;

    int total = 0;
    int bad   = 0;

    // Reference state: in-flight numbers oldest first, next number to hand out.
    int q[$];
    int next_sn = 0;
    bit err_m   = 0;

    always #5 clk = ~clk;

    rob_sn_alloc #(
        .p_depth    (DEPTH),
        .p_ptrwidth (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ROB_SN_ALLOC_FLUSH_EN
        .flush      (fl),
`endif
        .alloc_en   (alloc_en),
        .alloc_cpl  (alloc_cpl),
        .alloc_sn   (alloc_sn),
        .free_en    (free_en),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .free_err   (free_err)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the queue model,
    // then advance the model as the DUT will at the coming edge.
    task automatic step(input bit a, input bit f, input bit r, input bit fli);
        int  pre;
        bit  exp_cpl;
        int  exp_sn;
        bit  do_flush;
        @(negedge clk);
        alloc_en = a;
        free_en  = f;
        rst      = r;
`ifdef ROB_SN_ALLOC_FLUSH_EN
        fl       = fli;
`else
        fl       = 1'b0;
`endif
        do_flush = fl;
        #1;
        pre     = q.size();
        exp_cpl = !r && !do_flush && a && (pre < DEPTH);
        exp_sn  = r ? 0 : next_sn;
        check("alloc_cpl", int'(alloc_cpl), int'(exp_cpl));
        check("alloc_sn",  int'(alloc_sn),  exp_sn);
        check("count",     int'(count),     r ? 0 : pre);
        check("full",      int'(full),      (!r && pre == DEPTH) ? 1 : 0);
        check("empty",     int'(empty),     (r || pre == 0) ? 1 : 0);
        check("free_err",  int'(free_err),  (!r && err_m) ? 1 : 0);
        if (r) begin
            q.delete();
            next_sn = 0;
            err_m   = 0;
        end else if (do_flush) begin
            // The next number handed out is the oldest abandoned one.
            next_sn = (next_sn + DEPTH - pre) % DEPTH;
            q.delete();
        end else begin
            if (f) begin
                if (pre > 0) void'(q.pop_front());
                else         err_m = 1;
            end
            if (exp_cpl) begin
                q.push_back(next_sn);
                next_sn = (next_sn + 1) % DEPTH;
            end
        end
    endtask

    initial begin
        // Reset, then fill: numbers 0..3 granted, 5th request refused.
        step(1, 1, 1, 0);
        check("rst_count", int'(count), 0);
        step(1, 0, 0, 0);
        check("fill_sn0", int'(alloc_sn), 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("fill_sn3", int'(alloc_sn), 3);
        step(1, 0, 0, 0);
        check("full_refuse", int'(alloc_cpl), 0);
        check("full_count",  int'(count), 4);

        // Full with alloc and free together: alloc refused, then wrap to 0.
        step(1, 1, 0, 0);
        check("full_af_cpl", int'(alloc_cpl), 0);
        step(1, 0, 0, 0);
        check("wrap_count3", int'(count), 3);
        check("wrap_sn0",    int'(alloc_sn), 0);
        check("wrap_cpl",    int'(alloc_cpl), 1);

        // Count 2 with simultaneous alloc and free: count holds.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("both_count2", int'(count), 2);

        // Drain, then free while empty: sticky error until reset.
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("err_sticky", int'(free_err), 1);
        step(1, 0, 0, 0);

        // Reset mid-operation with alloc requested.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("rst_cpl", int'(alloc_cpl), 0);
        step(0, 0, 0, 0);
        check("post_rst_sn",    int'(alloc_sn), 0);
        check("post_rst_empty", int'(empty), 1);

`ifdef ROB_SN_ALLOC_FLUSH_EN
        // free_ptr=1, alloc_ptr=3, then flush with alloc requested.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 1);
        check("flush_cpl", int'(alloc_cpl), 0);
        step(0, 0, 0, 0);
        check("flush_sn",    int'(alloc_sn), 1);
        check("flush_count", int'(count), 0);
`endif

        // Randomized traffic with phases biased toward filling or draining.
        for (int i = 0; i < 3000; i++) begin
            int pa;
            pa = ((i / 100) % 2 == 0) ? 75 : 35;
            step($urandom_range(0, 99) < pa,
                 $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, limit reached");
        $fatal(1);
    end

endmodule : tb_rob_sn_alloc
`default_nettype wire

// File: doc/rob_sn_alloc.md
ROB_SN_ALLOC -- requirements
Module: rob_sn_alloc

Interface
REQ-001 SHALL have parameter p_depth, default 32, ROB entry count; power of two, >= 2.
REQ-002 SHALL have parameter p_ptrwidth, default $clog2(p_depth), sequence-number width.
REQ-003 SHALL have clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have alloc_en  input  1  dispatch requests one sequence number this cycle.
REQ-006 SHALL have alloc_cpl  output  1  allocation granted this cycle.
REQ-007 SHALL have alloc_sn  output  p_ptrwidth  sequence number granted; valid when alloc_cpl=1.
REQ-008 SHALL have free_en  input  1  ROB front dequeued this cycle; driven by the ROB's deq_front_cpl.
REQ-009 SHALL have count  output  p_ptrwidth+1  in-flight entries, 0..p_depth.
REQ-010 SHALL have full  output  1  count == p_depth.
REQ-011 SHALL have empty  output  1  count == 0.
REQ-012 SHALL have free_err  output  1  sticky; set on free_en while empty.

Function
REQ-013 SHALL hold alloc_ptr and free_ptr (p_ptrwidth bits each) and count as the only state, plus the free_err flag.
REQ-014 SHALL drive alloc_sn = alloc_ptr combinationally, every cycle.
REQ-015 SHALL drive alloc_cpl = alloc_en && !full combinationally, in the same cycle with zero latency; no full-cycle bypass, so alloc while full with free_en is refused.
REQ-016 SHALL, on grant, advance alloc_ptr by 1 modulo p_depth at the next edge; wrap from p_depth-1 to 0.
REQ-017 SHALL, on free_en with count > 0, advance free_ptr by 1 modulo p_depth at the next edge.
REQ-018 SHALL update count as +1 on grant only, -1 on valid free only, and unchanged when both or neither occur.
REQ-019 SHALL ignore free_en when empty (no pointer or count change) and set free_err, which stays set until rst.
REQ-020 SHALL derive full and empty combinationally from registered count.
REQ-021 SHALL keep sequence numbers unique among in-flight entries: alloc_ptr - free_ptr mod p_depth == count mod p_depth at all times.

Reset
REQ-022 SHALL, while rst=1, clear alloc_ptr, free_ptr, count and free_err at the edge; during that cycle outputs SHALL be alloc_cpl=0, alloc_sn=0, count=0, full=0, empty=1, free_err=0.
REQ-023 SHALL discard any alloc_en/free_en asserted in a reset cycle; reset mid-operation abandons all in-flight numbers and the ROB is reset together with this block.

Configuration
REQ-024 SHALL, when ROB_SN_ALLOC_FLUSH_EN is defined, add input flush (1 bit): at the edge, alloc_ptr <= free_ptr and count <= 0; alloc_cpl is forced 0 in a flush cycle; free_en in a flush cycle is ignored without setting free_err; flush has priority below rst.
REQ-025 SHALL, when ROB_SN_ALLOC_FLUSH_EN is undefined, have no flush port and no flush logic.

Structure
REQ-026 SHALL place the default depth constant and an sn_t typedef (p_ptrwidth-wide) in shared package rob_pkg, also used by rob_CtrlUnit.
REQ-027 SHALL instantiate sub-module rob_WrapPtr twice, for alloc_ptr and free_ptr: a modulo-p_depth pointer with synchronous clear, inc, and (flush build only) load.

Verification
REQ-028 SHALL cover: p_depth=4, reset, then alloc_en=1 for 4 cycles -> alloc_sn 0,1,2,3 with alloc_cpl=1; 5th cycle alloc_cpl=0, full=1, count=4.
REQ-029 SHALL cover: full, alloc_en=1 and free_en=1 same cycle -> alloc_cpl=0; next cycle count=3, full=0, then alloc grants sn=0 (wrap).
REQ-030 SHALL cover: count=2, alloc_en and free_en both high -> alloc_cpl=1, count stays 2, both pointers advance.
REQ-031 SHALL cover: empty, free_en=1 -> count stays 0, free_err=1 and remains 1 until rst.
REQ-032 SHALL cover: count=3, rst=1 with alloc_en=1 -> alloc_cpl=0; next cycle count=0, alloc_sn=0, empty=1.
REQ-033 SHALL cover (ROB_SN_ALLOC_FLUSH_EN): free_ptr=1, alloc_ptr=3, flush=1 with alloc_en=1 -> alloc_cpl=0; next cycle alloc_sn=1, count=0.
